phase_timer_sched: RTL and testbench
====================================

Name: phase_timer_sched

Overview:
Timer resource behind the appliance phase controller. It decodes the controller's 2-bit timer_select load request, loads the matching phase duration and counts it down on a prescaled tick. It then returns a single-cycle timer_elapsed pulse to the controller. Supports lid-open pause/resume and a synchronous abort, so the controller's phase sequencing stays purely combinational.

Parameters:
PRESCALE, 1000, clk cycles per countdown tick (>=1)
CNT_W, 16, width of remaining-tick counter
DUR_1, 30, ticks for phase 1 (select 2'b01, agitate)
DUR_2, 10, ticks for phase 2 (select 2'b10, rest)
DUR_3, 60, ticks for phase 3 (select 2'b11, heat)
WARN_TICKS, 5, warning threshold (used only with optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
timer_select  in  2  load request; 00 = none, 01/10/11 = load DUR_1/2/3; one-cycle pulse from controller
lid_open  in  1  level; pauses countdown while high
abort  in  1  synchronous cancel; returns to IDLE
timer_elapsed  out  1  one-cycle pulse when loaded duration expires
remaining  out  CNT_W  ticks left in current phase
busy  out  1  high in RUN, PAUSE or DONE
paused  out  1  high in PAUSE
warn  out  1  optional; see Optional Feature; tied 0 when excluded

Behaviour:
- Reset (async): state IDLE, prescaler 0, remaining 0, timer_elapsed 0, busy 0, paused 0, warn 0.
- All outputs registered or Moore-decoded from state; no combinational path from inputs to outputs.
- States: IDLE, RUN, PAUSE, DONE.
- Load: timer_select != 00 sampled on a clk edge does the following:
  - remaining <= DUR_n; prescaler cleared.
  - Next state is RUN, or PAUSE if lid_open is high.
  - Accepted in every state, so a load during RUN/PAUSE restarts with the new duration.
- Loaded duration of 0: next state DONE directly.
- RUN:
  - Prescaler counts 0..PRESCALE-1; each wrap is one tick.
  - On a tick, remaining decrements.
  - The tick that makes remaining 0 moves to DONE.
  - Latency: timer_elapsed goes high exactly DUR_n*PRESCALE cycles after the load edge.
- PAUSE:
  - Entered from RUN when lid_open is high.
  - Prescaler and remaining frozen.
  - Returns to RUN on the first cycle lid_open is low; the prescaler resumes from its frozen value, not cleared.
- DONE:
  - timer_elapsed = 1 for exactly one cycle.
  - Next state IDLE, unless timer_select != 00 in the same cycle; that load is taken (back-to-back phases), and RUN/PAUSE follows with no gap.
- IDLE: remaining holds 0; select 00 is no action.
- Priority: rst > abort > load > lid_open pause > tick.
- abort: state IDLE, remaining 0, prescaler 0, no timer_elapsed pulse; it also overrides a simultaneous load.
- remaining never underflows; it saturates at 0.

Optional Feature:
Macro PHASE_TIMER_WARN_EN.
- Defined: warn is registered and high while state is RUN or PAUSE and 0 < remaining <= WARN_TICKS; low otherwise; cleared by rst/abort.
- Undefined: warn is tied 0; no compare logic and WARN_TICKS is unused.

Decomposition:
- Package phase_timer_pkg:
  - State enum (IDLE, RUN, PAUSE, DONE).
  - Select encodings SEL_NONE=2'b00, SEL_AGITATE=2'b01, SEL_REST=2'b10, SEL_HEAT=2'b11.
  - Function mapping a select code to its duration.
- One sub-module, tick_prescaler:
  - Inputs: clk, rst, clear, enable.
  - Output: tick pulse.
  - PRESCALE parameter.

Test Plan:
- PRESCALE=4, DUR_1=3; pulse select=01 at edge 0 -> remaining 3,2,1,0 at edges 4,8,12; timer_elapsed high only in cycle after edge 12; busy falls after edge 13.
- Back-to-back phases: on the elapsed cycle, controller drives select=10 (DUR_2=2) -> no idle cycle, remaining=2 next cycle, second elapsed 8 cycles later.
- Pause: lid_open high for 10 cycles mid-phase 1 -> remaining and prescaler frozen, paused=1; elapsed delayed by exactly 10 cycles.
- Reload during RUN: select=11 when remaining=2 -> remaining=DUR_3=60; no elapsed pulse for the aborted phase.
- abort asserted together with select=01 in RUN -> IDLE, remaining=0, no elapsed. Separately, rst mid-count -> all outputs 0 immediately, asynchronously.
- PHASE_TIMER_WARN_EN, WARN_TICKS=2, DUR_1=3 -> warn high while remaining is 2 and 1, low at 3 and after DONE. With macro undefined -> warn stays 0.

Source files
------------

// File: rtl/phase_timer_sched_pkg.sv
// Shared definitions for the phase timer: state encoding, controller select codes
// and the select-to-duration lookup used when a phase is loaded.
package phase_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam logic [1:0] SEL_NONE    = 2'b00;
  localparam logic [1:0] SEL_AGITATE = 2'b01;
  localparam logic [1:0] SEL_REST    = 2'b10;
  localparam logic [1:0] SEL_HEAT    = 2'b11;

  function automatic logic [31:0] sel_duration(
    input logic [1:0]  sel,
    input logic [31:0] dur_1,
    input logic [31:0] dur_2,
    input logic [31:0] dur_3
  );
    logic [31:0] d;
    case (sel)
      SEL_AGITATE: d = dur_1;
      SEL_REST:    d = dur_2;
      SEL_HEAT:    d = dur_3;
      default:     d = 32'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/phase_timer_sched_if.sv
// Controller <-> timer link: load request, lid/abort controls and timer status.
interface phase_timer_sched_if #(
  parameter int unsigned CNT_W = 16
);
  logic [1:0]       timer_select;
  logic             lid_open;
  logic             abort;
  logic             timer_elapsed;
  logic [CNT_W-1:0] remaining;
  logic             busy;
  logic             paused;
  logic             warn;

  modport master (
    output timer_select, lid_open, abort,
    input  timer_elapsed, remaining, busy, paused, warn
  );

  modport slave (
    input  timer_select, lid_open, abort,
    output timer_elapsed, remaining, busy, paused, warn
  );
endinterface

// File: rtl/phase_timer_sched_tick_prescaler.sv
// Free-running divider producing one tick every PRESCALE enabled cycles; holds its
// count while disabled so a paused phase resumes mid-tick.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] count_r;
  logic          wrap_s;

  assign wrap_s = (count_r == LAST);
  assign tick   = enable && wrap_s && !clear;

  // Prescale counter: cleared on load/abort, frozen while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {PW{1'b0}};
    end else if (clear) begin
      count_r <= {PW{1'b0}};
    end else if (enable) begin
      count_r <= wrap_s ? {PW{1'b0}} : count_r + PW'(1);
    end
  end

endmodule

// File: rtl/phase_timer_sched.sv
// Phase duration timer: loads a duration on a controller select pulse and counts it down
// on prescaled ticks. Define PHASE_TIMER_WARN_EN to build the near-expiry warn output.
module phase_timer_sched
  import phase_timer_pkg::*;
#(
  parameter int unsigned PRESCALE   = 1000,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DUR_1      = 30,
  parameter int unsigned DUR_2      = 10,
  parameter int unsigned DUR_3      = 60,
  parameter int unsigned WARN_TICKS = 5
) (
  input logic               clk,
  input logic               rst,
  phase_timer_sched_if.slave bus
);

  state_e           state_r;
  state_e           state_next_s;
  logic [CNT_W-1:0] remaining_r;
  logic [CNT_W-1:0] rem_next_s;
  logic [31:0]      load_full_s;
  logic [CNT_W-1:0] load_dur_s;
  logic             load_s;
  logic             counting_s;
  logic             clr_s;
  logic             cnt_en_s;
  logic             tick_s;

  assign load_s      = (bus.timer_select != SEL_NONE);
  assign load_full_s = sel_duration(bus.timer_select, 32'(DUR_1), 32'(DUR_2), 32'(DUR_3));
  assign load_dur_s  = load_full_s[CNT_W-1:0];
  assign counting_s  = (state_r == RUN) || (state_r == PAUSE);
  assign clr_s       = bus.abort || load_s;
  assign cnt_en_s    = counting_s && !bus.lid_open && !clr_s;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (clr_s),
    .enable (cnt_en_s),
    .tick   (tick_s)
  );

  // Next-state and next-remaining: abort, then load, then pause, then tick.
  always_comb begin
    state_next_s = state_r;
    rem_next_s   = remaining_r;
    if (bus.abort) begin
      state_next_s = IDLE;
      rem_next_s   = {CNT_W{1'b0}};
    end else if (load_s) begin
      rem_next_s = load_dur_s;
      if (load_dur_s == {CNT_W{1'b0}}) begin
        state_next_s = DONE;
      end else if (bus.lid_open) begin
        state_next_s = PAUSE;
      end else begin
        state_next_s = RUN;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_next_s = IDLE;
          rem_next_s   = {CNT_W{1'b0}};
        end
        RUN, PAUSE: begin
          if (bus.lid_open) begin
            state_next_s = PAUSE;
          end else if (tick_s) begin
            // Saturating decrement; the tick reaching zero ends the phase.
            if (remaining_r <= CNT_W'(1)) begin
              rem_next_s   = {CNT_W{1'b0}};
              state_next_s = DONE;
            end else begin
              rem_next_s   = remaining_r - CNT_W'(1);
              state_next_s = RUN;
            end
          end else begin
            state_next_s = RUN;
          end
        end
        DONE: begin
          state_next_s = IDLE;
          rem_next_s   = {CNT_W{1'b0}};
        end
        default: begin
          state_next_s = IDLE;
          rem_next_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State and remaining-tick registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      remaining_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_next_s;
      remaining_r <= rem_next_s;
    end
  end

  assign bus.remaining     = remaining_r;
  assign bus.timer_elapsed = (state_r == DONE);
  assign bus.busy          = (state_r != IDLE);
  assign bus.paused        = (state_r == PAUSE);

`ifdef PHASE_TIMER_WARN_EN
  logic warn_r;

  // Warn computed from next values so it stays aligned with state/remaining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warn_r <= 1'b0;
    end else begin
      warn_r <= ((state_next_s == RUN) || (state_next_s == PAUSE)) &&
                (rem_next_s != {CNT_W{1'b0}}) &&
                (rem_next_s <= CNT_W'(WARN_TICKS));
    end
  end

  assign bus.warn = warn_r;
`else
  assign bus.warn = 1'b0;
`endif

endmodule

// File: tb/tb_phase_timer_sched.sv
// Directed bench for phase_timer_sched with PRESCALE=4, DUR_1=3, DUR_2=2, DUR_3=60, WARN_TICKS=2.
module tb_phase_timer_sched;
  import phase_timer_pkg::*;

  localparam int unsigned CNT_W = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  bit   warn_en;

  phase_timer_sched_if #(.CNT_W(CNT_W)) bus ();

  phase_timer_sched #(
    .PRESCALE   (4),
    .CNT_W      (CNT_W),
    .DUR_1      (3),
    .DUR_2      (2),
    .DUR_3      (60),
    .WARN_TICKS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] sel);
    bus.timer_select = sel;
    step();
    bus.timer_select = SEL_NONE;
  endtask

  function automatic int p1_rem(input int e);
    if (e < 4) return 3;
    else if (e < 8) return 2;
    else if (e < 12) return 1;
    else return 0;
  endfunction

  // Phase 1 (3 ticks of 4 cycles) from load edge 0, optional lid-open window.
  task automatic run_phase1(input int ps, input int len);
    load(SEL_AGITATE);
    chk("load_rem", 32'(bus.remaining), 32'd3);
    chk("load_busy", 32'(bus.busy), 32'd1);
    for (int e = 1; e <= 14 + len; e++) begin
      int eff;
      bit in_p;
      in_p = (len > 0) && (e >= ps) && (e < ps + len);
      bus.lid_open = in_p;
      step();
      if (len == 0 || e < ps) eff = e;
      else if (e < ps + len) eff = ps - 1;
      else eff = e - len;
      chk("p1_rem", 32'(bus.remaining), 32'(p1_rem(eff)));
      chk("p1_elapsed", 32'(bus.timer_elapsed), 32'(!in_p && eff == 12));
      chk("p1_busy", 32'(bus.busy), 32'(eff <= 12));
      chk("p1_paused", 32'(bus.paused), 32'(in_p));
      chk("p1_warn", 32'(bus.warn), 32'(warn_en && eff >= 4 && eff <= 11));
    end
    bus.lid_open = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
`ifdef PHASE_TIMER_WARN_EN
    warn_en = 1'b1;
`else
    warn_en = 1'b0;
`endif
    bus.timer_select = SEL_NONE;
    bus.lid_open     = 1'b0;
    bus.abort        = 1'b0;
    rst              = 1'b1;
    repeat (3) step();
    chk("rst_rem", 32'(bus.remaining), 32'd0);
    chk("rst_elapsed", 32'(bus.timer_elapsed), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_paused", 32'(bus.paused), 32'd0);
    chk("rst_warn", 32'(bus.warn), 32'd0);
    rst = 1'b0;
    step();
    step();
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Basic countdown, then the same phase with a 10-cycle lid-open pause.
    run_phase1(0, 0);
    run_phase1(6, 10);

    // Back-to-back: select REST during the elapsed cycle.
    load(SEL_AGITATE);
    for (int e = 1; e <= 22; e++) begin
      int er;
      bus.timer_select = (e == 13) ? SEL_REST : SEL_NONE;
      step();
      if (e <= 12) er = p1_rem(e);
      else if (e <= 16) er = 2;
      else if (e <= 20) er = 1;
      else er = 0;
      chk("b2b_rem", 32'(bus.remaining), 32'(er));
      chk("b2b_elapsed", 32'(bus.timer_elapsed), 32'(e == 12 || e == 21));
      chk("b2b_busy", 32'(bus.busy), 32'(e <= 21));
    end
    bus.timer_select = SEL_NONE;

    // Reload with HEAT while remaining is 2; the old phase must not fire.
    load(SEL_AGITATE);
    repeat (5) step();
    chk("rl_pre_rem", 32'(bus.remaining), 32'd2);
    load(SEL_HEAT);
    chk("rl_rem", 32'(bus.remaining), 32'd60);
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("rl_rem_cnt", 32'(bus.remaining), 32'(60 - k / 4));
      chk("rl_elapsed", 32'(bus.timer_elapsed), 32'd0);
    end

    // Abort wins over a simultaneous load.
    bus.abort        = 1'b1;
    bus.timer_select = SEL_AGITATE;
    step();
    bus.abort        = 1'b0;
    bus.timer_select = SEL_NONE;
    chk("ab_rem", 32'(bus.remaining), 32'd0);
    chk("ab_busy", 32'(bus.busy), 32'd0);
    chk("ab_elapsed", 32'(bus.timer_elapsed), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("ab_idle_elapsed", 32'(bus.timer_elapsed), 32'd0);
      chk("ab_idle_busy", 32'(bus.busy), 32'd0);
    end

    // Load while the lid is open goes straight to PAUSE and holds.
    bus.lid_open = 1'b1;
    load(SEL_AGITATE);
    chk("lp_paused", 32'(bus.paused), 32'd1);
    chk("lp_rem", 32'(bus.remaining), 32'd3);
    repeat (6) step();
    chk("lp_hold_rem", 32'(bus.remaining), 32'd3);
    chk("lp_hold_paused", 32'(bus.paused), 32'd1);
    bus.lid_open = 1'b0;
    bus.abort    = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("lp_abort_busy", 32'(bus.busy), 32'd0);

    // Asynchronous reset mid-count, checked between clock edges.
    load(SEL_HEAT);
    repeat (5) step();
    chk("ar_pre_busy", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_rem", 32'(bus.remaining), 32'd0);
    chk("ar_busy", 32'(bus.busy), 32'd0);
    chk("ar_paused", 32'(bus.paused), 32'd0);
    chk("ar_elapsed", 32'(bus.timer_elapsed), 32'd0);
    chk("ar_warn", 32'(bus.warn), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("ar_after_busy", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
